// File: rtl/spiking_activation_unit.sv
`default_nettype none
// ============================================================================
// Module      : spiking_activation_unit
// Description : Multi-channel integrate-and-fire activation stage. Each
//               accepted input beat is one timestep: every channel adds its
//               current into a registered membrane potential (saturating),
//               fires when the potential reaches the shared threshold, and
//               counts its spikes over a window of NUM_STEPS timesteps.
// Ports       : clk                - clock, rising edge
//               rstn               - asynchronous active-low reset
//               start              - begin a new window (sampled in IDLE)
//               reset_mode         - 0: membrane to zero after a spike,
//                                    1: subtract threshold after a spike
//               threshold          - signed firing threshold, all channels
//               in_valid/in_ready  - timestep handshake
//               current            - packed signed per-channel currents
//               spikes             - per-channel spike flags, last beat
//               accumulated_spikes - packed saturating per-channel counts
//               busy               - high while a window is running
//               done               - one-cycle pulse at window completion
// Options     : define SPIKING_ACTIVATION_LEAK_EN to decay the membrane by
//               v >>> LEAK_SHIFT before integration on active beats.
// Revision    : 1.0 - initial release
// ============================================================================
module spiking_activation_unit #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int NUM_STEPS    = 16,
    parameter int REFRAC_STEPS = 2,
    parameter int LEAK_SHIFT   = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         reset_mode,
    input  logic [DATA_WIDTH-1:0]        threshold,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] current,
    output logic [NUM_CH-1:0]            spikes,
    output logic [NUM_CH*CNT_WIDTH-1:0]  accumulated_spikes,
    output logic                         busy,
    output logic                         done
);

    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    localparam logic [RW-1:0]        C_REFRAC    = RW'(REFRAC_STEPS);
    localparam logic [SW-1:0]        C_LAST_STEP = SW'(NUM_STEPS - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic signed [DATA_WIDTH-1:0] C_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] C_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (NUM_STEPS < 1 || NUM_CH < 1 || LEAK_SHIFT < 0) begin : g_param_check
        $error("spiking_activation_unit: illegal parameter value");
    end

    // Clamp a one-bit-wider signed result back into DATA_WIDTH. Overflow is
    // visible as the two top bits disagreeing; the top bit gives the sign.
    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] x);
        if (x[DATA_WIDTH] != x[DATA_WIDTH-1]) begin
            return x[DATA_WIDTH] ? C_MIN : C_MAX;
        end
        return x[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]                   state_q, state_d;
    logic [SW-1:0]                step_q, step_d;
    logic [NUM_CH-1:0]            spikes_q, spikes_d;
    logic signed [DATA_WIDTH-1:0] v_q [NUM_CH];
    logic signed [DATA_WIDTH-1:0] v_d [NUM_CH];
    logic [RW-1:0]                refr_q [NUM_CH];
    logic [RW-1:0]                refr_d [NUM_CH];
    logic [CNT_WIDTH-1:0]         cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]         cnt_d [NUM_CH];

    logic signed [DATA_WIDTH-1:0] w_thr;
    logic signed [DATA_WIDTH-1:0] w_vsum [NUM_CH];
    logic signed [DATA_WIDTH-1:0] w_vsub [NUM_CH];
    logic [NUM_CH-1:0]            w_fire;

    assign w_thr = threshold;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] w_cur;
        logic signed [DATA_WIDTH-1:0] w_vin;

        assign w_cur = current[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef SPIKING_ACTIVATION_LEAK_EN
        // v - (v >>> s) cannot overflow for s >= 1, so no clamp is needed.
        assign w_vin = v_q[g] - (v_q[g] >>> LEAK_SHIFT);
`else
        assign w_vin = v_q[g];
`endif
        assign w_vsum[g] = sat({w_vin[DATA_WIDTH-1], w_vin} + {w_cur[DATA_WIDTH-1], w_cur});
        assign w_vsub[g] = sat({w_vsum[g][DATA_WIDTH-1], w_vsum[g]} - {w_thr[DATA_WIDTH-1], w_thr});
        assign w_fire[g] = (w_vsum[g] >= w_thr);

        assign accumulated_spikes[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        spikes_d = spikes_q;
        for (int i = 0; i < NUM_CH; i++) begin
            v_d[i]    = v_q[i];
            refr_d[i] = refr_q[i];
            cnt_d[i]  = cnt_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    step_d   = '0;
                    spikes_d = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        v_d[i]    = '0;
                        refr_d[i] = '0;
                        cnt_d[i]  = '0;
                    end
                end
            end
            S_RUN: begin
                // in_ready is high throughout RUN, so in_valid alone accepts.
                if (in_valid) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (refr_q[i] != '0) begin
                            refr_d[i]   = refr_q[i] - RW'(1);
                            spikes_d[i] = 1'b0;
                        end else if (w_fire[i]) begin
                            spikes_d[i] = 1'b1;
                            refr_d[i]   = C_REFRAC;
                            v_d[i]      = reset_mode ? w_vsub[i] : '0;
                            if (cnt_q[i] != C_CNT_MAX) begin
                                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                            end
                        end else begin
                            spikes_d[i] = 1'b0;
                            v_d[i]      = w_vsum[i];
                        end
                    end
                    if (step_q == C_LAST_STEP) begin
                        step_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            spikes_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            spikes_q <= spikes_d;
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i]    <= v_d[i];
                refr_q[i] <= refr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign in_ready = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign spikes   = spikes_q;

endmodule
`default_nettype wire

// File: tb/tb_spiking_activation_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_spiking_activation_unit
// Description : Scoreboard bench for spiking_activation_unit. Three instances
//               share one stimulus stream: A (no refractory, 8-bit counts),
//               B (refractory 2, 8-bit counts), C (no refractory, 3-bit
//               counts). A driver updates a plain-integer neuron model and
//               queues the expected outputs for every cycle; a monitor pops
//               and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spiking_activation_unit;

    localparam int DW     = 16;
    localparam int NCH    = 4;
    localparam int NSTEPS = 16;
    localparam int NDUT   = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            reset_mode;
    logic [DW-1:0]   threshold;
    logic            in_valid;
    logic [NCH*DW-1:0] current;

    logic            rdy_a, busy_a, done_a;
    logic            rdy_b, busy_b, done_b;
    logic            rdy_c, busy_c, done_c;
    logic [NCH-1:0]  spk_a, spk_b, spk_c;
    logic [31:0]     acc_a, acc_b;
    logic [11:0]     acc_c;

    always #5 clk = ~clk;

    spiking_activation_unit #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(8),
        .NUM_STEPS(NSTEPS), .REFRAC_STEPS(0), .LEAK_SHIFT(4)) u_a (
        .clk(clk), .rstn(rstn), .start(start), .reset_mode(reset_mode),
        .threshold(threshold), .in_valid(in_valid), .in_ready(rdy_a),
        .current(current), .spikes(spk_a), .accumulated_spikes(acc_a),
        .busy(busy_a), .done(done_a));

    spiking_activation_unit #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(8),
        .NUM_STEPS(NSTEPS), .REFRAC_STEPS(2), .LEAK_SHIFT(4)) u_b (
        .clk(clk), .rstn(rstn), .start(start), .reset_mode(reset_mode),
        .threshold(threshold), .in_valid(in_valid), .in_ready(rdy_b),
        .current(current), .spikes(spk_b), .accumulated_spikes(acc_b),
        .busy(busy_b), .done(done_b));

    spiking_activation_unit #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(3),
        .NUM_STEPS(NSTEPS), .REFRAC_STEPS(0), .LEAK_SHIFT(4)) u_c (
        .clk(clk), .rstn(rstn), .start(start), .reset_mode(reset_mode),
        .threshold(threshold), .in_valid(in_valid), .in_ready(rdy_c),
        .current(current), .spikes(spk_c), .accumulated_spikes(acc_c),
        .busy(busy_c), .done(done_c));

    typedef struct packed {
        logic [2:0]  ctl;   // {in_ready, busy, done}
        logic [11:0] spk;   // 4 bits per instance, A in the low nibble
        logic [31:0] acc_a;
        logic [31:0] acc_b;
        logic [11:0] acc_c;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    // Behavioural model: window phase 0=idle, 1=running, 2=done.
    int mphase;
    int mstep;
    int mv [NDUT][NCH];
    int mr [NDUT][NCH];
    int mc [NDUT][NCH];
    bit ms [NDUT][NCH];
    int s_cur [NCH];

    function automatic int refr_of(int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 2) ? 7 : 255;
    endfunction

    function automatic int clamp16(int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        mphase = 0;
        mstep  = 0;
        for (int k = 0; k < NDUT; k++)
            for (int c = 0; c < NCH; c++) begin
                mv[k][c] = 0; mr[k][c] = 0; mc[k][c] = 0; ms[k][c] = 1'b0;
            end
    endtask

    task automatic model_edge(bit v, bit st, bit md, int thr);
        int s;
        case (mphase)
            0: if (st) begin
                model_reset();
                mphase = 1;
            end
            1: if (v) begin
                for (int k = 0; k < NDUT; k++)
                    for (int c = 0; c < NCH; c++) begin
                        if (mr[k][c] > 0) begin
                            mr[k][c]--;
                            ms[k][c] = 1'b0;
                        end else begin
                            s = clamp16(mv[k][c] + s_cur[c]);
                            if (s >= thr) begin
                                ms[k][c] = 1'b1;
                                mr[k][c] = refr_of(k);
                                if (mc[k][c] < cmax_of(k)) mc[k][c]++;
                                mv[k][c] = md ? clamp16(s - thr) : 0;
                            end else begin
                                ms[k][c] = 1'b0;
                                mv[k][c] = s;
                            end
                        end
                    end
                mstep++;
                if (mstep == NSTEPS) begin
                    mstep  = 0;
                    mphase = 2;
                end
            end
            default: mphase = 0;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        int   t;
        e.ctl = {mphase == 1, mphase == 1, mphase == 2};
        for (int k = 0; k < NDUT; k++)
            for (int c = 0; c < NCH; c++) e.spk[k*4+c] = ms[k][c];
        for (int c = 0; c < NCH; c++) begin
            t = mc[0][c]; e.acc_a[c*8 +: 8] = t[7:0];
            t = mc[1][c]; e.acc_b[c*8 +: 8] = t[7:0];
            t = mc[2][c]; e.acc_c[c*3 +: 3] = t[2:0];
        end
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: expectations for the cycle that just began are
    // queued first, then inputs for the coming edge are applied to both the
    // DUTs and the model.
    task automatic step(bit rst, bit v, bit st, bit md, int thr);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            rstn = 1'b0;
            model_reset();
        end else begin
            rstn = 1'b1;
        end
        push_exp();
        mon_en     = 1'b1;
        in_valid   = v;
        start      = st;
        reset_mode = md;
        threshold  = thr[DW-1:0];
        for (int c = 0; c < NCH; c++) current[c*DW +: DW] = s_cur[c][DW-1:0];
        if (!rst) model_edge(v, st, md, thr);
    endtask

    function automatic int rnd_current();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32767;
        if (r == 1) return -32768;
        return int'($urandom_range(0, 400)) - 150;
    endfunction

    task automatic set_all(int x);
        for (int c = 0; c < NCH; c++) s_cur[c] = x;
    endtask

    // Start a window and keep stepping until the model is back in idle.
    // md < 0 picks reset_mode randomly per beat.
    task automatic run_window(int thr, int md, bit rnd_cur, int vprob);
        int n;
        bit v, st, m;
        step(0, ($urandom_range(0, 1) == 1), 1'b1, 1'b0, thr);
        n = 0;
        while (mphase != 0 && n < 400) begin
            if (rnd_cur) for (int c = 0; c < NCH; c++) s_cur[c] = rnd_current();
            v  = (int'($urandom_range(0, 99)) < vprob);
            st = ($urandom_range(0, 3) == 0);
            m  = (md < 0) ? ($urandom_range(0, 1) == 1) : md[0];
            step(1'b0, v, st, m, thr);
            n++;
        end
        step(1'b0, ($urandom_range(0, 1) == 1), 1'b0, 1'b0, thr);
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ctl_a", {29'd0, rdy_a, busy_a, done_a}, {29'd0, e.ctl});
                    chk("ctl_b", {29'd0, rdy_b, busy_b, done_b}, {29'd0, e.ctl});
                    chk("ctl_c", {29'd0, rdy_c, busy_c, done_c}, {29'd0, e.ctl});
                    chk("spikes_a", {28'd0, spk_a}, {28'd0, e.spk[3:0]});
                    chk("spikes_b", {28'd0, spk_b}, {28'd0, e.spk[7:4]});
                    chk("spikes_c", {28'd0, spk_c}, {28'd0, e.spk[11:8]});
                    chk("counts_a", acc_a, e.acc_a);
                    chk("counts_b", acc_b, e.acc_b);
                    chk("counts_c", {20'd0, acc_c}, {20'd0, e.acc_c});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; reset_mode = 1'b0;
        threshold = '0; current = '0;
        set_all(0);
        model_reset();

        // Reset with busy-looking inputs: everything must stay cleared.
        set_all(500);
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 100);

        // Constant currents, reset to zero.
        s_cur = '{30, 50, 100, 0};
        run_window(100, 0, 1'b0, 100);
        chk("w1_const_a", acc_a, 32'h0010_0804);
        chk("w1_const_c", {20'd0, acc_c}, 32'h0000_01FC);

        // Subtractive reset: 70 into threshold 100 gives 11 spikes in 16.
        set_all(70);
        run_window(100, 1, 1'b0, 100);
        chk("w2_const_a", acc_a, 32'h0B0B_0B0B);

        // Refractory: B fires on beats 1,4,7,...,16; valid is throttled.
        set_all(20);
        run_window(10, 0, 1'b0, 60);
        chk("w3_const_b", acc_b, 32'h0606_0606);
        chk("w3_const_a", acc_a, 32'h1010_1010);

        // Membrane saturation: 0x4000+0x4000 must clamp to 0x7FFF and fire.
        set_all(16384);
        run_window(32767, 1, 1'b0, 100);
        chk("w4_sat_a", acc_a, 32'h0808_0808);

        // Counter saturation: a spike every beat holds the 3-bit count at 7.
        set_all(32767);
        run_window(32767, 0, 1'b0, 80);
        chk("w5_sat_c", {20'd0, acc_c}, 32'h0000_0FFF);

        // Negative threshold with zero current fires every beat.
        set_all(0);
        run_window(-5, 0, 1'b0, 100);
        chk("w6_negthr_a", acc_a, 32'h1010_1010);

        // Randomised windows.
        for (int w = 0; w < 6; w++) begin
            int thr;
            thr = (w % 3 == 0) ? (int'($urandom_range(0, 65535)) - 32768)
                               : (int'($urandom_range(0, 300)) - 50);
            run_window(thr, -1, 1'b1, 70);
        end

        // Reset mid-window after 5 beats with nonzero counts.
        set_all(100);
        step(1'b0, 1'b0, 1'b1, 1'b0, 50);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 50);
        step(1'b1, 1'b1, 1'b0, 1'b0, 50);
        step(1'b1, 1'b1, 1'b0, 1'b0, 50);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 50);
        chk("midrst_counts_a", acc_a, 32'h0000_0000);

        // Recovery after reset.
        run_window(120, -1, 1'b1, 75);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spiking_activation_unit.md
Name: spiking_activation_unit

Overview:
- Multi-channel integrate-and-fire activation stage.
- Each channel integrates an input current into a registered membrane potential and fires a spike when the potential reaches a shared threshold.
- Each channel counts its spikes over a fixed window of NUM_STEPS timesteps.
- Sits after the PE-array accumulators. Each accepted input beat is one timestep. Per-channel spike counts are presented to the next layer when the window completes.

Parameters:
- DATA_WIDTH, 16: signed width of currents, threshold and membrane potentials.
- NUM_CH, 4: number of independent neuron channels.
- CNT_WIDTH, 8: width of each per-channel spike counter; the counter saturates.
- NUM_STEPS, 16: timesteps per window; minimum 1.
- REFRAC_STEPS, 2: timesteps a channel ignores input after firing; 0 disables the refractory period.
- LEAK_SHIFT, 4: leak shift amount; used only when LEAK_EN is defined.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- start, input, 1: begins a new window; sampled only in IDLE.
- reset_mode, input, 1: 0 = reset to zero after a spike, 1 = reset by subtracting the threshold. Sampled every accepted beat.
- threshold, input, DATA_WIDTH: signed firing threshold shared by all channels.
- in_valid, input, 1: current bus holds one timestep of data.
- in_ready, output, 1: unit accepts a timestep this cycle.
- current, input, NUM_CH*DATA_WIDTH: packed signed currents; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- spikes, output, NUM_CH: registered per-channel spike flags for the last accepted beat.
- accumulated_spikes, output, NUM_CH*CNT_WIDTH: packed per-channel spike counts.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse when a window completes.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State goes to IDLE.
  - All membrane potentials, refractory counters, spike counters and the step counter clear to 0.
  - spikes, done, busy and in_ready drive 0.
  - Reset mid-window abandons the window; no done pulse is produced.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=0; accumulated_spikes holds the last window's result.
  - start=1 clears the membranes, refractory counters, spike counters, spikes and step counter, then moves to RUN next cycle.
- RUN:
  - busy=1 and in_ready=1. A beat is accepted when in_valid && in_ready.
  - start is ignored.
  - Cycles without an accepted beat change nothing, and spikes holds its value.
- Per channel on each accepted beat:
  - If refractory count > 0: decrement it, leave the membrane unchanged, spike=0.
  - Otherwise compute v_sum = v + current as a saturating signed add, clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If v_sum >= threshold (signed compare): spike=1, refractory count = REFRAC_STEPS, spike counter += 1 saturating at 2^CNT_WIDTH-1. The new membrane is 0 when reset_mode=0, or v_sum - threshold (saturating) when reset_mode=1.
  - Otherwise: spike=0 and the membrane becomes v_sum.
- Latency: spikes and counters reflect a beat on the cycle after it is accepted (1 cycle).
- Step counter:
  - Increments on every accepted beat.
  - On the beat that is number NUM_STEPS the counter wraps to 0 and the state moves to DONE. That beat's spikes and counts still update.
- DONE:
  - done=1 for exactly one cycle; in_ready=0; busy=0.
  - Moves to IDLE next cycle.
  - accumulated_spikes is stable from the done cycle until the next start.
- Negative thresholds are legal. A channel with threshold <= 0 and zero current fires on every non-refractory beat.

Optional Feature:
- Macro: SPIKING_ACTIVATION_LEAK_EN.
- Defined: before integration, the membrane decays as v_leak = v - (v >>> LEAK_SHIFT), using an arithmetic shift. Then v_sum = v_leak + current, saturating. Leak is applied only on accepted, non-refractory beats.
- Undefined: no leak; the LEAK_SHIFT parameter is unused; behaviour is exactly as in Behaviour.

Test Plan:
- Reset low mid-RUN (after 5 beats, with counts nonzero) -> all outputs and accumulated_spikes = 0, state IDLE, no done pulse.
- NUM_CH=4, threshold=100, reset_mode=0, REFRAC_STEPS=0, constant currents {30,50,100,0}, NUM_STEPS=16 -> final counts {4,8,16,0}; done pulses once, exactly 1 cycle after the 16th accepted beat.
- reset_mode=1, threshold=100, current=70, REFRAC_STEPS=0 -> membrane sequence 70, 40, 10, 80, 50, 20, 90, 60, 30, 0; spikes on beats 2, 3, 5, 6, 8, 9, 10.
- REFRAC_STEPS=2, threshold=10, current=20, 9 beats -> spikes on beats 1, 4, 7 only; count = 3.
- Saturation: current=0x7FFF every beat with threshold=0x7FFF, and separately CNT_WIDTH=3 with a spike every beat over 16 steps -> membrane clamps at 0x7FFF with no wrap; counter holds at 7.
- Handshake: in_valid toggled randomly, plus start asserted during RUN -> only accepted beats advance the step counter; start has no effect; in_ready=0 in IDLE and DONE.
